// File: rtl/tweezer_pkg.sv
// ============================================================================
// Module : tweezer_pkg
// Brief  : Shared FSM state type, default widths and signed saturation helper
//          for the tweezer PI controller bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tweezer_pkg;

  localparam int DEF_N_CH      = 3;
  localparam int DEF_IN_W      = 16;
  localparam int DEF_IN_FRAC   = 15;
  localparam int DEF_OUT_W     = 16;
  localparam int DEF_OUT_FRAC  = 15;
  localparam int DEF_COEF_W    = 10;
  localparam int DEF_COEF_FRAC = 9;
  localparam int DEF_ACC_W     = 40;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    MUL  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Clamp x into the signed range of a w-bit word (w <= 64).
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    if (x >= lim)
      return lim - 64'sd1;
    else if (x < -lim)
      return -lim;
    else
      return x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tweezer_pi_bank_if.sv
// ============================================================================
// Module : tweezer_pi_bank_if
// Brief  : Sample/control/result bundle of the tweezer PI bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tweezer_pi_bank_if #(
  parameter int N_CH   = 3,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int COEF_W = 10
);
  logic [N_CH*IN_W-1:0]   in_data;
  logic                   in_valid;
  logic [N_CH*IN_W-1:0]   setpoint;
  logic [N_CH*COEF_W-1:0] kp;
  logic [N_CH*COEF_W-1:0] ki;
  logic [N_CH-1:0]        pi_enable;
  logic [N_CH-1:0]        pi_freeze;
  logic [N_CH-1:0]        pi_reset;
  logic                   overrun_clr;
  logic [N_CH*OUT_W-1:0]  out_data;
  logic                   out_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output in_data, in_valid, setpoint, kp, ki,
           pi_enable, pi_freeze, pi_reset, overrun_clr,
    input  out_data, out_valid, busy, overrun
  );

  modport slave (
    input  in_data, in_valid, setpoint, kp, ki,
           pi_enable, pi_freeze, pi_reset, overrun_clr,
    output out_data, out_valid, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/pi_mac_lane.sv
// ============================================================================
// Module : pi_mac_lane
// Brief  : Shared error / multiply / accumulate lane with per-channel
//          integrators. Saturation enabled by TWEEZER_PI_BANK_SAT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pi_mac_lane
  import tweezer_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int IN_W   = DEF_IN_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_IN_FRAC + DEF_COEF_FRAC - DEF_OUT_FRAC,
  parameter int CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     err_en_i,
  input  logic                     mul_en_i,
  input  logic                     acc_en_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic signed [IN_W-1:0]   sample_i,
  input  logic signed [IN_W-1:0]   setpoint_i,
  input  logic signed [COEF_W-1:0] kp_i,
  input  logic signed [COEF_W-1:0] ki_i,
  input  logic                     freeze_i,
  input  logic                     clear_i,
  output logic signed [OUT_W-1:0]  y_o
);

  localparam int E_W = IN_W + 1;
  localparam int P_W = COEF_W + E_W;
  localparam int S_W = ACC_W + 1;

  logic signed [E_W-1:0]   err_q, err_d;
  logic signed [P_W-1:0]   p_q, p_d, i_q, i_d;
  logic signed [ACC_W-1:0] integ_q [N_CH];
  logic signed [ACC_W-1:0] integ_sum_d, integ_d;
  logic signed [S_W-1:0]   sum_wide_d, tot_d, tot_sh_d;
  logic signed [OUT_W-1:0] y_lim_d;

  always_comb begin
    err_d      = E_W'(setpoint_i) - E_W'(sample_i);
    p_d        = P_W'(kp_i) * P_W'(err_q);
    i_d        = P_W'(ki_i) * P_W'(err_q);
    sum_wide_d = S_W'(integ_q[ch_i]) + S_W'(i_q);
`ifdef TWEEZER_PI_BANK_SAT_EN
    integ_sum_d = ACC_W'(sat_s(64'(sum_wide_d), ACC_W));
`else
    integ_sum_d = ACC_W'(sum_wide_d);
`endif
    // Clearing wins over freeze so pi_reset always empties the integrator.
    if (clear_i)
      integ_d = '0;
    else if (freeze_i)
      integ_d = integ_q[ch_i];
    else
      integ_d = integ_sum_d;
    tot_d    = S_W'(p_q) + S_W'(integ_d);
    tot_sh_d = tot_d >>> SHIFT;
`ifdef TWEEZER_PI_BANK_SAT_EN
    y_lim_d = OUT_W'(sat_s(64'(tot_sh_d), OUT_W));
`else
    y_lim_d = OUT_W'(tot_sh_d);
`endif
    y_o = clear_i ? '0 : y_lim_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      p_q   <= '0;
      i_q   <= '0;
      for (int c = 0; c < N_CH; c++) integ_q[c] <= '0;
    end else begin
      if (err_en_i) err_q <= err_d;
      if (mul_en_i) begin
        p_q <= p_d;
        i_q <= i_d;
      end
      if (acc_en_i) integ_q[ch_i] <= integ_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tweezer_pi_bank.sv
// ============================================================================
// Module : tweezer_pi_bank
// Brief  : Time-multiplexed bank of PI controllers for optical tweezer axes.
//          Optional saturation via TWEEZER_PI_BANK_SAT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tweezer_pi_bank
  import tweezer_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int IN_W      = DEF_IN_W,
  parameter int IN_FRAC   = DEF_IN_FRAC,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int OUT_FRAC  = DEF_OUT_FRAC,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  tweezer_pi_bank_if.slave  bus
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SHIFT = IN_FRAC + COEF_FRAC - OUT_FRAC;
  localparam logic [CH_W-1:0] C_LAST = CH_W'(N_CH - 1);

  state_t                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic                    busy_q, out_valid_q, overrun_q;
  logic signed [IN_W-1:0]  smp_q [N_CH];
  logic signed [IN_W-1:0]  sp_q  [N_CH];
  logic signed [COEF_W-1:0] kp_q [N_CH];
  logic signed [COEF_W-1:0] ki_q [N_CH];
  logic [N_CH-1:0]         en_q, frz_q, prst_q;
  logic signed [OUT_W-1:0] res_q [N_CH];
  logic signed [OUT_W-1:0] out_q [N_CH];
  logic signed [OUT_W-1:0] lane_y;

  pi_mac_lane #(
    .N_CH(N_CH), .IN_W(IN_W), .COEF_W(COEF_W), .ACC_W(ACC_W),
    .OUT_W(OUT_W), .SHIFT(SHIFT), .CH_W(CH_W)
  ) u_lane (
    .clk        (clk),
    .rst_n      (rst_n),
    .err_en_i   (state_q == ERR),
    .mul_en_i   (state_q == MUL),
    .acc_en_i   (state_q == ACC),
    .ch_i       (ch_q),
    .sample_i   (smp_q[ch_q]),
    .setpoint_i (sp_q[ch_q]),
    .kp_i       (kp_q[ch_q]),
    .ki_i       (ki_q[ch_q]),
    .freeze_i   (frz_q[ch_q]),
    .clear_i    (~en_q[ch_q] | prst_q[ch_q]),
    .y_o        (lane_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      en_q        <= '0;
      frz_q       <= '0;
      prst_q      <= '0;
      for (int c = 0; c < N_CH; c++) begin
        smp_q[c] <= '0;
        sp_q[c]  <= '0;
        kp_q[c]  <= '0;
        ki_q[c]  <= '0;
        res_q[c] <= '0;
        out_q[c] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      // A new overrun outranks a simultaneous clear.
      if (bus.in_valid && busy_q)
        overrun_q <= 1'b1;
      else if (bus.overrun_clr)
        overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int c = 0; c < N_CH; c++) begin
              smp_q[c] <= bus.in_data[c*IN_W +: IN_W];
              sp_q[c]  <= bus.setpoint[c*IN_W +: IN_W];
              kp_q[c]  <= bus.kp[c*COEF_W +: COEF_W];
              ki_q[c]  <= bus.ki[c*COEF_W +: COEF_W];
            end
            en_q    <= bus.pi_enable;
            frz_q   <= bus.pi_freeze;
            prst_q  <= bus.pi_reset;
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= ERR;
          end
        end
        ERR: state_q <= MUL;
        MUL: state_q <= ACC;
        ACC: begin
          res_q[ch_q] <= lane_y;
          if (ch_q == C_LAST) begin
            // Publish the whole set at once so out_data moves only with out_valid.
            for (int c = 0; c < N_CH; c++)
              out_q[c] <= (CH_W'(c) == ch_q) ? lane_y : res_q[c];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            ch_q    <= ch_q + CH_W'(1);
            state_q <= ERR;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_pack
      assign bus.out_data[g*OUT_W +: OUT_W] = out_q[g];
    end
  endgenerate

  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_tweezer_pi_bank.sv
// ============================================================================
// Module : tb_tweezer_pi_bank
// Brief  : Directed, table-driven bench for tweezer_pi_bank (N_CH=3).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tweezer_pi_bank;

  localparam int N = 3, IW = 16, OW = 16, CW = 10;
`ifdef TWEEZER_PI_BANK_SAT_EN
  localparam logic [15:0] SAT2 = 16'h7FFF;
`else
  localparam logic [15:0] SAT2 = 16'hFF7F;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tweezer_pi_bank_if #(.N_CH(N), .IN_W(IW), .OUT_W(OW), .COEF_W(CW)) bus ();

  tweezer_pi_bank #(.N_CH(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [47:0] din;
    logic [47:0] sp;
    logic [29:0] kp;
    logic [29:0] ki;
    logic [2:0]  en;
    logic [2:0]  frz;
    logic [2:0]  prst;
    logic [47:0] exp;
  } vec_t;

  vec_t tv [8];
  vec_t vo;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_data   = v.din;
    bus.setpoint  = v.sp;
    bus.kp        = v.kp;
    bus.ki        = v.ki;
    bus.pi_enable = v.en;
    bus.pi_freeze = v.frz;
    bus.pi_reset  = v.prst;
  endtask

  // Accept a set at the next edge, then disturb every input while busy.
  task automatic start_set(input vec_t v);
    @(negedge clk);
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_data   = ~v.din;
    bus.setpoint  = ~v.sp;
    bus.kp        = ~v.kp;
    bus.ki        = ~v.ki;
    bus.pi_enable = ~v.en;
    bus.pi_freeze = ~v.frz;
    bus.pi_reset  = ~v.prst;
  endtask

  task automatic run_set(input vec_t v, output int lat, output logic [47:0] od);
    start_set(v);
    lat = -1;
    od  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        od  = bus.out_data;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, pulses, pcyc;
    logic [47:0] od;

    // ch0 proportional, ch1 integral, ch2 per vector
    tv[0] = '{48'h0000_0000_E000, 48'h0000_2000_0000, 30'h0000_0100, 30'h0004_0000,
              3'b011, 3'b000, 3'b000, 48'h0000_1000_1000};
    tv[1] = tv[0]; tv[1].exp = 48'h0000_2000_1000;
    tv[2] = tv[0]; tv[2].exp = 48'h0000_3000_1000;
    tv[3] = tv[0]; tv[3].frz = 3'b010; tv[3].exp = 48'h0000_3000_1000;
    tv[4] = tv[3];
    tv[5] = tv[3]; tv[5].prst = 3'b010; tv[5].exp = 48'h0000_0000_1000;
    tv[6] = '{48'h8000_0000_E000, 48'h7FFF_2000_0000, {10'h1FF, 10'h000, 10'h100},
              30'h0004_0000, 3'b111, 3'b000, 3'b000, {SAT2, 32'h1000_1000}};
    tv[7] = '{48'h0000_0000_0001, 48'h4000_0000_0000, {10'h200, 10'h000, 10'h001},
              30'h0, 3'b101, 3'b000, 3'b000, 48'hC000_0000_FFFF};
    vo = tv[0];

    bus.in_data = '0; bus.setpoint = '0; bus.kp = '0; bus.ki = '0;
    bus.pi_enable = '0; bus.pi_freeze = '0; bus.pi_reset = '0;
    bus.in_valid = 1'b0; bus.overrun_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_data", bus.out_data, 48'h0);
    chk("rst_out_valid", 48'(bus.out_valid), 48'h0);
    chk("rst_busy", 48'(bus.busy), 48'h0);
    chk("rst_overrun", 48'(bus.overrun), 48'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_set(tv[i], lat, od);
      chk($sformatf("vec%0d_latency", i), 48'(lat), 48'd10);
      chk($sformatf("vec%0d_out", i), od, tv[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_low", i), 48'(bus.busy), 48'h0);
    end

    // Overrun: second strobe at cycle 4 is dropped and flagged.
    start_set(vo);
    pulses = 0; pcyc = -1; od = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin pulses++; pcyc = k; od = bus.out_data; end
      if (k == 1) chk("ovr_busy_c1", 48'(bus.busy), 48'h1);
      if (k == 4) begin
        chk("ovr_pre", 48'(bus.overrun), 48'h0);
        bus.in_valid = 1'b1;
      end
      if (k == 5) begin
        bus.in_valid = 1'b0;
        chk("ovr_set_c5", 48'(bus.overrun), 48'h1);
      end
    end
    chk("ovr_pulses", 48'(pulses), 48'd1);
    chk("ovr_pulse_cycle", 48'(pcyc), 48'd10);
    chk("ovr_out", od, 48'h0000_1000_1000);
    chk("ovr_sticky", 48'(bus.overrun), 48'h1);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    chk("ovr_cleared", 48'(bus.overrun), 48'h0);

    // Clear and new overrun in the same cycle: flag stays set.
    start_set(vo);
    od = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.out_valid) od = bus.out_data;
      if (k == 3) begin bus.in_valid = 1'b1; bus.overrun_clr = 1'b1; end
      if (k == 4) begin
        bus.in_valid = 1'b0; bus.overrun_clr = 1'b0;
        chk("ovr_clr_race", 48'(bus.overrun), 48'h1);
      end
    end
    chk("race_out", od, 48'h0000_2000_1000);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;

    // Reset mid-operation aborts the set and empties integrators.
    start_set(vo);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 5) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 48'(bus.busy), 48'h0);
        chk("midrst_out", bus.out_data, 48'h0);
      end
      if (k == 7) rst_n = 1'b1;
      if (bus.out_valid) pulses++;
    end
    chk("midrst_no_pulse", 48'(pulses), 48'd0);
    run_set(vo, lat, od);
    chk("postrst_latency", 48'(lat), 48'd10);
    chk("postrst_out", od, 48'h0000_1000_1000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tweezer_pi_bank.md
TWEEZER_PI_BANK -- requirements
Module: tweezer_pi_bank

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of controlled axes (x, y, z), 1..8.
REQ-002 SHALL have parameter IN_W, default 16, and IN_FRAC, default 15: signed input width and fractional bits.
REQ-003 SHALL have parameter OUT_W, default 16, and OUT_FRAC, default 15: signed output width and fractional bits.
REQ-004 SHALL have parameter COEF_W, default 10, and COEF_FRAC, default 9: signed gain width and fractional bits.
REQ-005 SHALL have parameter ACC_W, default 40: signed integrator width, fixed at IN_FRAC+COEF_FRAC fractional bits.
REQ-006 SHALL have one clock; reset is asynchronous and active-low. The ports are: clk, input, 1 bit, single clock; reset, input, 1 bit, asynchronous active-low reset.
REQ-007 in_data, input, N_CH*IN_W bits: packed signed samples, with channel 0 in the LSBs.
REQ-008 in_valid, input, 1 bit: sample-set strobe.
REQ-009 setpoint, input, N_CH*IN_W bits: packed signed setpoints.
REQ-010 kp, input, N_CH*COEF_W bits; ki, input, N_CH*COEF_W bits: packed signed gains.
REQ-011 pi_enable, pi_freeze and pi_reset, inputs, N_CH bits each: per-channel control bits.
REQ-012 out_data, output, N_CH*OUT_W bits: packed signed controller outputs.
REQ-013 out_valid, output, 1 bit: one-cycle pulse when all channels have been updated.
REQ-014 busy, output, 1 bit: high while a sample set is being processed.
REQ-015 overrun, output, 1 bit: sticky flag, set when in_valid arrives while busy.
REQ-016 overrun_clr, input, 1 bit: clears overrun.

Function
REQ-017 Channels SHALL share one multiply/accumulate lane, time-multiplexed in ascending channel order.
REQ-018 FSM states SHALL be IDLE, ERR, MUL, ACC, DONE.
- IDLE->ERR on in_valid, capturing in_data and all control and gain inputs.
- ERR->MUL->ACC, one cycle each, per channel.
- ACC->ERR for the next channel; ACC->DONE after channel N_CH-1.
- DONE->IDLE.
REQ-019 If in_valid is accepted at cycle 0, out_valid SHALL pulse at cycle 3*N_CH+1; busy SHALL be high during cycles 1..3*N_CH+1.
REQ-020 The ERR stage SHALL compute err = setpoint - in, sign-extended to IN_W+1 bits, with no overflow possible.
REQ-021 The MUL stage SHALL compute p = kp*err and i = ki*err as full-precision products.
REQ-022 In the ACC stage, if enable=1 and freeze=0, integ SHALL be updated to integ+i; if freeze=1, integ SHALL be held.
REQ-023 The channel output SHALL be p+integ, arithmetically shifted to OUT_FRAC (truncation toward minus infinity), then reduced to OUT_W.
REQ-024 When enable=0 or pi_reset=1 for a channel, integ SHALL be cleared and the output SHALL be 0; pi_reset SHALL take priority over freeze.
REQ-025 out_data SHALL change only in the cycle out_valid is asserted, and SHALL hold otherwise.
REQ-026 in_valid while busy SHALL be dropped and SHALL set overrun.
REQ-027 If overrun_clr and a new overrun occur in the same cycle, overrun SHALL remain set.
REQ-028 Control inputs SHALL be sampled only at acceptance; changes during busy SHALL affect the next set only.

Reset
REQ-029 Asserting reset SHALL clear all integrators, zero out_data, clear out_valid, busy and overrun, and force the FSM to IDLE.
REQ-030 Reset mid-operation SHALL abort the set with no out_valid; the first set after release SHALL start from zero integrators.

Configuration
REQ-031 With TWEEZER_PI_BANK_SAT_EN defined, integ SHALL saturate to the ACC_W signed range and the output SHALL saturate to the OUT_W signed range.
REQ-032 Without TWEEZER_PI_BANK_SAT_EN, integ and output SHALL wrap (two's-complement truncation).

Structure
REQ-033 Package tweezer_pkg SHALL hold the FSM state enum, the default width constants and a signed saturate function.
REQ-034 Sub-module pi_mac_lane SHALL contain the err/multiply/accumulate datapath; the top level SHALL contain the FSM, channel index, packing and flags.

Verification
All scenarios use N_CH=3 and default widths.
REQ-035 Proportional: kp0=256 (0.5), ki0=0, setpoint0=0, in0=0xE000 (-0.25), enable0=1, in_valid at cycle 0 -> out_data[15:0]=0x1000 (0.125), with out_valid at cycle 10.
REQ-036 Integral: kp=0, ki1=256, err1=+0.25 on three sets -> channel 1 outputs 0x1000, 0x2000, 0x3000.
REQ-037 Freeze and reset: after REQ-036, set freeze1=1 for two sets -> output stays 0x3000; then pi_reset1=1 -> output 0x0000, and the following set (pi_reset1=0, freeze1=0) -> output 0x1000.
REQ-038 Saturation: kp2=511, setpoint2=0x7FFF, in2=0x8000 -> with the macro out=0x7FFF; without the macro, the output equals the wrapped low 16 bits.
REQ-039 Overrun: in_valid at cycles 0 and 4 -> one out_valid at cycle 10, overrun=1 from cycle 5; overrun_clr -> overrun=0 the next cycle.
REQ-040 Reset mid-operation: reset low at cycle 5 -> out_data=0, busy=0, no out_valid pulse; a new set after release matches REQ-035.
